// File: rtl/otter_id_ex_stage_if.sv
// ID-to-EX bundle: hold/flush, ID instruction with decoder controls, and the registered EX view.
// Handshake: no valid/ready pair; ID_VALID/EX_VALID qualify each slot, and STALL asks upstream to hold.
interface otter_id_ex_stage_if #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 16
);
  logic             HOLD;
  logic             FLUSH;
  logic             ID_VALID;
  logic [XLEN-1:0]  ID_PC;
  logic [31:0]      ID_IR;
  logic [XLEN-1:0]  ID_RS1_DATA;
  logic [XLEN-1:0]  ID_RS2_DATA;
  logic             ID_ALU_SRCA;
  logic [1:0]       ID_ALU_SRCB;
  logic [3:0]       ID_ALU_FUN;
  logic [1:0]       ID_RF_WR_SEL;
  logic             ID_REGWRITE;
  logic             ID_MEMWRITE;
  logic             ID_MEMREAD2;

  logic             EX_VALID;
  logic [XLEN-1:0]  EX_PC;
  logic [31:0]      EX_IR;
  logic [XLEN-1:0]  EX_RS1_DATA;
  logic [XLEN-1:0]  EX_RS2_DATA;
  logic             EX_ALU_SRCA;
  logic [1:0]       EX_ALU_SRCB;
  logic [3:0]       EX_ALU_FUN;
  logic [1:0]       EX_RF_WR_SEL;
  logic             EX_REGWRITE;
  logic             EX_MEMWRITE;
  logic             EX_MEMREAD2;
  logic [4:0]       EX_RD;
  logic             STALL;
  logic [CNT_W-1:0] STALL_CNT;

  modport master (
    output HOLD, FLUSH, ID_VALID, ID_PC, ID_IR, ID_RS1_DATA, ID_RS2_DATA,
           ID_ALU_SRCA, ID_ALU_SRCB, ID_ALU_FUN, ID_RF_WR_SEL,
           ID_REGWRITE, ID_MEMWRITE, ID_MEMREAD2,
    input  EX_VALID, EX_PC, EX_IR, EX_RS1_DATA, EX_RS2_DATA,
           EX_ALU_SRCA, EX_ALU_SRCB, EX_ALU_FUN, EX_RF_WR_SEL,
           EX_REGWRITE, EX_MEMWRITE, EX_MEMREAD2, EX_RD, STALL, STALL_CNT
  );

  modport slave (
    input  HOLD, FLUSH, ID_VALID, ID_PC, ID_IR, ID_RS1_DATA, ID_RS2_DATA,
           ID_ALU_SRCA, ID_ALU_SRCB, ID_ALU_FUN, ID_RF_WR_SEL,
           ID_REGWRITE, ID_MEMWRITE, ID_MEMREAD2,
    output EX_VALID, EX_PC, EX_IR, EX_RS1_DATA, EX_RS2_DATA,
           EX_ALU_SRCA, EX_ALU_SRCB, EX_ALU_FUN, EX_RF_WR_SEL,
           EX_REGWRITE, EX_MEMWRITE, EX_MEMREAD2, EX_RD, STALL, STALL_CNT
  );
endinterface

// File: rtl/otter_id_ex_stage.sv
// ID/EX pipeline register for the pipelined OTTER: load-use stall, bubble injection,
// flush (remembered across HOLD) and a saturating stall counter. XLEN/CNT_W must match the bus.
module otter_id_ex_stage #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 16
) (
  input logic                CLK,
  input logic                RST_N,
  otter_id_ex_stage_if.slave bus
);
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;

  typedef struct packed {
    logic            valid;
    logic [XLEN-1:0] pc;
    logic [31:0]     ir;
    logic [XLEN-1:0] rs1_data;
    logic [XLEN-1:0] rs2_data;
    logic            alu_srca;
    logic [1:0]      alu_srcb;
    logic [3:0]      alu_fun;
    logic [1:0]      rf_wr_sel;
    logic            regwrite;
    logic            memwrite;
    logic            memread2;
  } ex_t;

  ex_t              r_ex;
  logic             r_flush_pending;
  logic [CNT_W-1:0] r_stall_cnt;

  ex_t        w_load;
  logic [6:0] w_opcode;
  logic [4:0] w_ex_rd;
  logic       w_uses_rs1;
  logic       w_uses_rs2;
  logic       w_hazard;
  logic       w_flush_eff;

  assign w_opcode   = bus.ID_IR[6:0];
  assign w_ex_rd    = r_ex.ir[11:7];
  assign w_uses_rs1 = !(w_opcode == OPC_LUI || w_opcode == OPC_AUIPC || w_opcode == OPC_JAL);
  assign w_uses_rs2 = (w_opcode == OPC_OP) || (w_opcode == OPC_BRANCH) || (w_opcode == OPC_STORE);

  // Only a load sitting in EX can produce data too late for forwarding.
  assign w_hazard = r_ex.valid && r_ex.memread2 && (w_ex_rd != 5'd0) && bus.ID_VALID &&
                    ((w_uses_rs1 && (w_ex_rd == bus.ID_IR[19:15])) ||
                     (w_uses_rs2 && (w_ex_rd == bus.ID_IR[24:20])));

  assign w_flush_eff = bus.FLUSH || r_flush_pending;

  always_comb begin
    w_load           = '0;
    w_load.valid     = bus.ID_VALID;
    w_load.pc        = bus.ID_PC;
    w_load.ir        = bus.ID_IR;
    w_load.rs1_data  = bus.ID_RS1_DATA;
    w_load.rs2_data  = bus.ID_RS2_DATA;
    w_load.alu_srca  = bus.ID_ALU_SRCA;
    w_load.alu_srcb  = bus.ID_ALU_SRCB;
    w_load.alu_fun   = bus.ID_ALU_FUN;
    w_load.rf_wr_sel = bus.ID_RF_WR_SEL;
    // An empty ID slot must never leave side effects behind in EX.
    w_load.regwrite  = bus.ID_REGWRITE && bus.ID_VALID;
    w_load.memwrite  = bus.ID_MEMWRITE && bus.ID_VALID;
    w_load.memread2  = bus.ID_MEMREAD2 && bus.ID_VALID;
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      r_ex            <= '0;
      r_flush_pending <= 1'b0;
      r_stall_cnt     <= '0;
    end else if (bus.HOLD) begin
      // A branch resolving during a memory wait must still kill ID once the pipe moves.
      if (bus.FLUSH) r_flush_pending <= 1'b1;
    end else if (w_flush_eff) begin
      r_ex            <= '0;
      r_flush_pending <= 1'b0;
    end else if (w_hazard) begin
      r_ex <= '0;
      if (r_stall_cnt != {CNT_W{1'b1}})
        r_stall_cnt <= r_stall_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      r_ex <= w_load;
    end
  end

  assign bus.EX_VALID     = r_ex.valid;
  assign bus.EX_PC        = r_ex.pc;
  assign bus.EX_IR        = r_ex.ir;
  assign bus.EX_RS1_DATA  = r_ex.rs1_data;
  assign bus.EX_RS2_DATA  = r_ex.rs2_data;
  assign bus.EX_ALU_SRCA  = r_ex.alu_srca;
  assign bus.EX_ALU_SRCB  = r_ex.alu_srcb;
  assign bus.EX_ALU_FUN   = r_ex.alu_fun;
  assign bus.EX_RF_WR_SEL = r_ex.rf_wr_sel;
  assign bus.EX_REGWRITE  = r_ex.regwrite;
  assign bus.EX_MEMWRITE  = r_ex.memwrite;
  assign bus.EX_MEMREAD2  = r_ex.memread2;
  assign bus.EX_RD        = w_ex_rd;
  assign bus.STALL        = w_hazard && !w_flush_eff && !bus.HOLD;
  assign bus.STALL_CNT    = r_stall_cnt;
endmodule

// File: tb/tb_otter_id_ex_stage.sv
// Directed bench for otter_id_ex_stage: a driver pushes the expected EX view per cycle,
// a monitor pops and compares it after each edge. A CNT_W=2 copy shares the stimulus.
module tb_otter_id_ex_stage;
  typedef struct packed {
    logic        valid;
    logic [31:0] pc;
    logic [31:0] ir;
    logic [31:0] rs1d;
    logic [31:0] rs2d;
    logic [3:0]  fun;
    logic        rw;
    logic        mr;
    logic        mw;
  } in_t;

  typedef struct packed {
    logic        chk;
    logic        stall;
    logic        valid;
    logic [31:0] pc;
    logic [31:0] ir;
    logic [4:0]  rd;
    logic [31:0] rs1;
    logic [3:0]  fun;
    logic        regwrite;
    logic        memwrite;
    logic        memread2;
    logic [15:0] cnt;
    logic [1:0]  cnt2;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;
  int   n_checks = 0;
  int   n_fail   = 0;
  exp_t exp_q[$];

  otter_id_ex_stage_if #(.XLEN(32), .CNT_W(16)) bus ();
  otter_id_ex_stage_if #(.XLEN(32), .CNT_W(2))  bus2 ();

  otter_id_ex_stage #(.XLEN(32), .CNT_W(16)) u_dut  (.CLK(clk), .RST_N(rst_n), .bus(bus));
  otter_id_ex_stage #(.XLEN(32), .CNT_W(2))  u_dut2 (.CLK(clk), .RST_N(rst_n), .bus(bus2));

  assign bus2.HOLD         = bus.HOLD;
  assign bus2.FLUSH        = bus.FLUSH;
  assign bus2.ID_VALID     = bus.ID_VALID;
  assign bus2.ID_PC        = bus.ID_PC;
  assign bus2.ID_IR        = bus.ID_IR;
  assign bus2.ID_RS1_DATA  = bus.ID_RS1_DATA;
  assign bus2.ID_RS2_DATA  = bus.ID_RS2_DATA;
  assign bus2.ID_ALU_SRCA  = bus.ID_ALU_SRCA;
  assign bus2.ID_ALU_SRCB  = bus.ID_ALU_SRCB;
  assign bus2.ID_ALU_FUN   = bus.ID_ALU_FUN;
  assign bus2.ID_RF_WR_SEL = bus.ID_RF_WR_SEL;
  assign bus2.ID_REGWRITE  = bus.ID_REGWRITE;
  assign bus2.ID_MEMWRITE  = bus.ID_MEMWRITE;
  assign bus2.ID_MEMREAD2  = bus.ID_MEMREAD2;

  // clock / reset
  always #5 clk = ~clk;

  // instruction encoders
  function automatic logic [31:0] r_add(input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2);
    return {7'd0, rs2, rs1, 3'b000, rd, 7'b0110011};
  endfunction
  function automatic logic [31:0] lw(input logic [4:0] rd, input logic [4:0] rs1);
    return {12'd0, rs1, 3'b010, rd, 7'b0000011};
  endfunction
  function automatic logic [31:0] lui(input logic [4:0] rd, input logic [19:0] imm);
    return {imm, rd, 7'b0110111};
  endfunction
  function automatic logic [31:0] addi(input logic [4:0] rd, input logic [4:0] rs1, input logic [11:0] imm);
    return {imm, rs1, 3'b000, rd, 7'b0010011};
  endfunction
  function automatic logic [31:0] sw(input logic [4:0] rs1, input logic [4:0] rs2);
    return {7'd0, rs2, rs1, 3'b010, 5'd0, 7'b0100011};
  endfunction

  function automatic in_t mk(input logic v, input logic [31:0] pc, input logic [31:0] ir,
                             input logic [31:0] d1, input logic [31:0] d2, input logic [3:0] fun,
                             input logic rw, input logic mr, input logic mw);
    in_t t;
    t.valid = v; t.pc = pc; t.ir = ir; t.rs1d = d1; t.rs2d = d2;
    t.fun = fun; t.rw = rw; t.mr = mr; t.mw = mw;
    return t;
  endfunction

  // expected EX views
  function automatic exp_t e_zero(input logic stall);
    exp_t e = '0;
    e.chk = 1'b1; e.stall = stall;
    return e;
  endfunction
  function automatic exp_t e_bub(input logic stall, input int cnt);
    exp_t e = '0;
    e.stall = stall; e.cnt = 16'(cnt); e.cnt2 = (cnt > 3) ? 2'd3 : 2'(cnt);
    return e;
  endfunction
  function automatic exp_t e_ld(input in_t t, input logic stall, input int cnt);
    exp_t e = '0;
    e.chk = 1'b1; e.stall = stall; e.valid = t.valid; e.pc = t.pc; e.ir = t.ir;
    e.rd = t.ir[11:7]; e.rs1 = t.rs1d; e.fun = t.fun;
    e.regwrite = t.rw & t.valid; e.memwrite = t.mw & t.valid; e.memread2 = t.mr & t.valid;
    e.cnt = 16'(cnt); e.cnt2 = (cnt > 3) ? 2'd3 : 2'(cnt);
    return e;
  endfunction

  // driver
  task automatic step(input logic rn, input logic hold, input logic flush, input in_t t, input exp_t e);
    @(negedge clk);
    rst_n            = rn;
    bus.HOLD         = hold;
    bus.FLUSH        = flush;
    bus.ID_VALID     = t.valid;
    bus.ID_PC        = t.pc;
    bus.ID_IR        = t.ir;
    bus.ID_RS1_DATA  = t.rs1d;
    bus.ID_RS2_DATA  = t.rs2d;
    bus.ID_ALU_SRCA  = t.ir[3];
    bus.ID_ALU_SRCB  = 2'b01;
    bus.ID_ALU_FUN   = t.fun;
    bus.ID_RF_WR_SEL = 2'b10;
    bus.ID_REGWRITE  = t.rw;
    bus.ID_MEMWRITE  = t.mw;
    bus.ID_MEMREAD2  = t.mr;
    exp_q.push_back(e);
  endtask

  // scoreboard
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s @%0t: got 0x%0h expected 0x%0h", name, $time, act, exp);
    end
  endtask

  initial begin : monitor
    logic s1, s2;
    exp_t e;
    forever begin
      @(negedge clk);
      #2;
      s1 = bus.STALL;
      s2 = bus2.STALL;
      @(posedge clk);
      #1;
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        check("stall",     32'(s1), 32'(e.stall));
        check("stall2",    32'(s2), 32'(e.stall));
        check("ex_valid",  32'(bus.EX_VALID), 32'(e.valid));
        check("regwrite",  32'(bus.EX_REGWRITE), 32'(e.regwrite));
        check("memwrite",  32'(bus.EX_MEMWRITE), 32'(e.memwrite));
        check("memread2",  32'(bus.EX_MEMREAD2), 32'(e.memread2));
        check("stall_cnt", 32'(bus.STALL_CNT), 32'(e.cnt));
        check("stall_cnt_sat", 32'(bus2.STALL_CNT), 32'(e.cnt2));
        if (e.chk) begin
          check("ex_pc",  bus.EX_PC, e.pc);
          check("ex_ir",  bus.EX_IR, e.ir);
          check("ex_rd",  32'(bus.EX_RD), 32'(e.rd));
          check("ex_rs1", bus.EX_RS1_DATA, e.rs1);
          check("ex_fun", 32'(bus.EX_ALU_FUN), 32'(e.fun));
        end
      end
    end
  end

  initial begin : watchdog
    #100000;
    n_fail++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin : stimulus
    in_t nop, a, l, u, h, c;
    exp_t keep;
    int waited;
    rst_n = 1'b0;
    bus.HOLD = 1'b1; bus.FLUSH = 1'b1; bus.ID_VALID = 1'b0;
    bus.ID_PC = '0; bus.ID_IR = '0; bus.ID_RS1_DATA = '0; bus.ID_RS2_DATA = '0;
    bus.ID_ALU_SRCA = 1'b0; bus.ID_ALU_SRCB = '0; bus.ID_ALU_FUN = '0; bus.ID_RF_WR_SEL = '0;
    bus.ID_REGWRITE = 1'b0; bus.ID_MEMWRITE = 1'b0; bus.ID_MEMREAD2 = 1'b0;

    nop = mk(0, 0, 0, 0, 0, 0, 0, 0, 0);
    a   = mk(1, 32'h100, r_add(3, 1, 2), 5, 7, 4'd0, 1, 0, 0);
    step(0, 0, 0, nop, e_zero(0));
    step(0, 1, 1, a, e_zero(0));

    // pass-through and load-use
    step(1, 0, 0, a, e_ld(a, 0, 0));
    l = mk(1, 32'h104, lw(5, 1), 32'h11, 32'h12, 4'd0, 1, 1, 0);
    step(1, 0, 0, l, e_ld(l, 0, 0));
    u = mk(1, 32'h108, r_add(6, 5, 1), 32'h21, 32'h22, 4'd0, 1, 0, 0);
    step(1, 0, 0, u, e_bub(1, 1));
    step(1, 0, 0, u, e_ld(u, 0, 1));

    // no false hazards: rd=x0, LUI, ADDI with rs2 field 5
    l = mk(1, 32'h10c, lw(0, 2), 32'h31, 32'h32, 4'd0, 1, 1, 0);
    step(1, 0, 0, l, e_ld(l, 0, 1));
    u = mk(1, 32'h110, r_add(1, 0, 0), 32'h41, 32'h42, 4'd0, 1, 0, 0);
    step(1, 0, 0, u, e_ld(u, 0, 1));
    l = mk(1, 32'h114, lw(5, 1), 32'h51, 32'h52, 4'd0, 1, 1, 0);
    step(1, 0, 0, l, e_ld(l, 0, 1));
    u = mk(1, 32'h118, lui(5, 20'h00028), 32'h61, 32'h62, 4'd9, 1, 0, 0);
    step(1, 0, 0, u, e_ld(u, 0, 1));
    l = mk(1, 32'h11c, lw(5, 1), 32'h71, 32'h72, 4'd0, 1, 1, 0);
    step(1, 0, 0, l, e_ld(l, 0, 1));
    u = mk(1, 32'h120, addi(7, 1, 12'h005), 32'h81, 32'h82, 4'd0, 1, 0, 0);
    step(1, 0, 0, u, e_ld(u, 0, 1));

    // flush under hold, the release cycle also has a live hazard
    l = mk(1, 32'h124, lw(8, 1), 32'h91, 32'h92, 4'd0, 1, 1, 0);
    keep = e_ld(l, 0, 1);
    step(1, 0, 0, l, keep);
    h = mk(1, 32'h128, r_add(9, 2, 3), 32'ha1, 32'ha2, 4'd0, 1, 0, 0);
    step(1, 1, 1, h, keep);
    step(1, 1, 0, h, keep);
    step(1, 1, 0, h, keep);
    h = mk(1, 32'h128, r_add(9, 8, 1), 32'ha1, 32'ha2, 4'd0, 1, 0, 0);
    step(1, 0, 0, h, e_bub(0, 1));
    step(1, 0, 0, h, e_ld(h, 0, 1));

    // live FLUSH together with a load-use hazard
    l = mk(1, 32'h12c, lw(10, 1), 32'hb1, 32'hb2, 4'd0, 1, 1, 0);
    step(1, 0, 0, l, e_ld(l, 0, 1));
    u = mk(1, 32'h130, r_add(11, 10, 0), 32'hc1, 32'hc2, 4'd0, 1, 0, 0);
    step(1, 0, 1, u, e_bub(0, 1));
    step(1, 0, 0, u, e_ld(u, 0, 1));

    // four more load-use stalls via rs1, rs2, store rs2, both
    for (int k = 0; k < 4; k++) begin
      l = mk(1, 32'h140 + 32'(16 * k), lw(12, 1), 32'hd0 + 32'(k), 32'he0, 4'd0, 1, 1, 0);
      case (k)
        0: c = mk(1, 32'h144 + 32'(16 * k), r_add(13, 12, 0), 32'hf0, 32'hf1, 4'd0, 1, 0, 0);
        1: c = mk(1, 32'h144 + 32'(16 * k), r_add(13, 0, 12), 32'hf0, 32'hf1, 4'd8, 1, 0, 0);
        2: c = mk(1, 32'h144 + 32'(16 * k), sw(0, 12), 32'hf0, 32'hf1, 4'd0, 0, 0, 1);
        default: c = mk(1, 32'h144 + 32'(16 * k), r_add(13, 12, 12), 32'hf0, 32'hf1, 4'd7, 1, 0, 0);
      endcase
      step(1, 0, 0, l, e_ld(l, 0, 1 + k));
      step(1, 0, 0, c, e_bub(1, 2 + k));
      step(1, 0, 0, c, e_ld(c, 0, 2 + k));
    end

    // empty ID slot carries data but no side effects, so no hazard follows
    l = mk(0, 32'h200, lw(14, 1), 32'h111, 32'h112, 4'd0, 1, 1, 0);
    step(1, 0, 0, l, e_ld(l, 0, 5));
    u = mk(1, 32'h204, r_add(15, 14, 0), 32'h121, 32'h122, 4'd0, 1, 0, 0);
    step(1, 0, 0, u, e_ld(u, 0, 5));

    // reset in the middle of a stall
    l = mk(1, 32'h208, lw(16, 1), 32'h131, 32'h132, 4'd0, 1, 1, 0);
    step(1, 0, 0, l, e_ld(l, 0, 5));
    u = mk(1, 32'h20c, r_add(17, 16, 0), 32'h141, 32'h142, 4'd0, 1, 0, 0);
    step(0, 0, 0, u, e_zero(1));
    step(1, 0, 0, u, e_ld(u, 0, 0));

    waited = 0;
    while (exp_q.size() != 0 && waited < 10) begin
      @(posedge clk);
      waited++;
    end
    #3;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
